// File: rtl/mem_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_param
// Purpose  : Pipeline memory stage with a valid/ready handshake on both sides.
//            LOAD and STORE access a private data memory with a programmable
//            latency. PASS forwards the ALU result straight to writeback.
//            Addresses whose upper bits are non-zero are flagged with addr_err
//            and never touch memory.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clkwire        in   1       clock, rising edge active
//   resetwire_n    in   1       asynchronous active-low reset
//   in_valid       in   1       upstream request valid
//   in_ready       out  1       stage idle and able to accept a request
//   instruction    in   4       4'b0011 LOAD, 4'b0001 STORE, other PASS
//   aluoutput      in   DATA_W  effective address or PASS result
//   storedata      in   DATA_W  STORE data
//   registernum    in   REG_W   destination register
//   out_valid      out  1       writeback result valid
//   out_ready      in   1       writeback stage accepts the result
//   writedata      out  DATA_W  writeback value
//   checkwritedata out  1       register-file write enable
//   regnum         out  REG_W   destination register of the result
//   addr_err       out  1       result came from an out-of-range LOAD/STORE
// ============================================================================
module mem_stage_param #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int REG_W  = 4,
   parameter int LAT    = 2
) (
   input  logic              clkwire,
   input  logic              resetwire_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        instruction,
   input  logic [DATA_W-1:0] aluoutput,
   input  logic [DATA_W-1:0] storedata,
   input  logic [REG_W-1:0]  registernum,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] writedata,
   output logic              checkwritedata,
   output logic [REG_W-1:0]  regnum,
   output logic              addr_err
);

   localparam logic [3:0] OP_LOAD  = 4'b0011;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam int         CNT_W    = 3;
   localparam int         DEPTH    = 1 << ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                is_load_q, is_load_d;
   logic                is_store_q, is_store_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   sdata_q, sdata_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                cwd_q, cwd_d;
   logic [REG_W-1:0]    regnum_q, regnum_d;
   logic                err_q, err_d;

   // Data memory is deliberately not reset.
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                w_in_range;
   logic [ADDR_W-1:0]   w_idx;
   logic                w_access;
   logic                w_mem_we;

   // In range only when every bit above the word index is zero.
   assign w_in_range = ((addr_q >> ADDR_W) == '0);
   assign w_idx      = addr_q[ADDR_W-1:0];
   // The single edge on which the memory is actually touched.
   assign w_access   = (state_q == S_ACCESS) && (cnt_q == '0);
   assign w_mem_we   = w_access && is_store_q && w_in_range;

   assign in_ready       = (state_q == S_IDLE);
   assign out_valid      = (state_q == S_RESP);
   assign writedata      = wdata_q;
   assign checkwritedata = cwd_q;
   assign regnum         = regnum_q;
   assign addr_err       = err_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_load_d  = is_load_q;
      is_store_d = is_store_q;
      addr_d     = addr_q;
      sdata_d    = sdata_q;
      wdata_d    = wdata_q;
      cwd_d      = cwd_q;
      regnum_d   = regnum_q;
      err_d      = err_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               is_load_d  = (instruction == OP_LOAD);
               is_store_d = (instruction == OP_STORE);
               addr_d     = aluoutput;
               sdata_d    = storedata;
               regnum_d   = registernum;
               if ((instruction == OP_LOAD) || (instruction == OP_STORE)) begin
                  state_d = S_ACCESS;
                  cnt_d   = CNT_W'(LAT - 1);
               end else begin
                  // PASS skips memory and produces its result immediately.
                  state_d = S_RESP;
                  wdata_d = aluoutput;
                  cwd_d   = 1'b1;
                  err_d   = 1'b0;
               end
            end
         end

         S_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
               if (!w_in_range) begin
                  wdata_d = '0;
                  cwd_d   = 1'b0;
                  err_d   = 1'b1;
               end else if (is_load_q) begin
                  // Old contents: a LOAD never writes, so no collision here.
                  wdata_d = mem_q[w_idx];
                  cwd_d   = 1'b1;
                  err_d   = 1'b0;
               end else begin
                  wdata_d = '0;
                  cwd_d   = 1'b0;
                  err_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_RESP: begin
            // Result held until accepted; returning to IDLE leaves one
            // idle cycle before the next result can appear.
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clkwire or negedge resetwire_n) begin
      if (!resetwire_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         is_load_q  <= 1'b0;
         is_store_q <= 1'b0;
         addr_q     <= '0;
         sdata_q    <= '0;
         wdata_q    <= '0;
         cwd_q      <= 1'b0;
         regnum_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_load_q  <= is_load_d;
         is_store_q <= is_store_d;
         addr_q     <= addr_d;
         sdata_q    <= sdata_d;
         wdata_q    <= wdata_d;
         cwd_q      <= cwd_d;
         regnum_q   <= regnum_d;
         err_q      <= err_d;
      end
   end

   // Write enable is derived from the reset state register, so a reset
   // during ACCESS cancels a pending STORE.
   always_ff @(posedge clkwire) begin
      if (w_mem_we) begin
         mem_q[w_idx] <= sdata_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_param
// Purpose  : Directed self-checking bench for mem_stage_param. Instance 0
//            uses LAT=2; instances 1 and 2 use LAT=1 and LAT=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_param;

   localparam logic [3:0] OP_LOAD  = 4'b0011;
   localparam logic [3:0] OP_STORE = 4'b0001;

   logic        clk;
   logic        rst_n;
   logic [2:0]  iv;
   logic [2:0]  ir;
   logic [3:0]  instr;
   logic [15:0] alu;
   logic [15:0] sd;
   logic [3:0]  rn;
   logic [2:0]  ov;
   logic        ordy;
   logic [15:0] wd  [3];
   logic [2:0]  cwd;
   logic [3:0]  rno [3];
   logic [2:0]  aerr;

   int n_chk  = 0;
   int n_pass = 0;

   mem_stage_param #(.DATA_W(16), .ADDR_W(4), .REG_W(4), .LAT(2)) u_dut0 (
      .clkwire(clk), .resetwire_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .instruction(instr), .aluoutput(alu), .storedata(sd), .registernum(rn),
      .out_valid(ov[0]), .out_ready(ordy), .writedata(wd[0]),
      .checkwritedata(cwd[0]), .regnum(rno[0]), .addr_err(aerr[0]));

   mem_stage_param #(.DATA_W(16), .ADDR_W(4), .REG_W(4), .LAT(1)) u_dut1 (
      .clkwire(clk), .resetwire_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .instruction(instr), .aluoutput(alu), .storedata(sd), .registernum(rn),
      .out_valid(ov[1]), .out_ready(ordy), .writedata(wd[1]),
      .checkwritedata(cwd[1]), .regnum(rno[1]), .addr_err(aerr[1]));

   mem_stage_param #(.DATA_W(16), .ADDR_W(4), .REG_W(4), .LAT(8)) u_dut8 (
      .clkwire(clk), .resetwire_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .instruction(instr), .aluoutput(alu), .storedata(sd), .registernum(rn),
      .out_valid(ov[2]), .out_ready(ordy), .writedata(wd[2]),
      .checkwritedata(cwd[2]), .regnum(rno[2]), .addr_err(aerr[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one request to instance sel; returns 1 ns after the accept edge.
   task automatic issue(input int sel, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] d, input logic [3:0] r);
      @(negedge clk);
      instr   = op;
      alu     = a;
      sd      = d;
      rn      = r;
      iv[sel] = 1'b1;
      @(posedge clk);
      #1;
      iv = 3'b000;
   endtask

   // Edges after the accept edge until out_valid is seen (bounded).
   task automatic wait_valid(input int sel, output int lat);
      lat = 0;
      while (ov[sel] !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic drain;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; iv = 3'b000; ordy = 1'b1;
      instr = 4'h0; alu = 16'h0; sd = 16'h0; rn = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (ov[0] !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", ov[0]); else n_pass++;
      n_chk++; if (wd[0] !== 16'h0) $display("FAIL rst_writedata: got %h exp 0000", wd[0]); else n_pass++;
      n_chk++; if ({cwd[0], aerr[0], rno[0]} !== 6'b0) $display("FAIL rst_cwd_err_regnum: got %b exp 000000", {cwd[0], aerr[0], rno[0]}); else n_pass++;
      // First accept on the very first edge after release.
      @(negedge clk);
      rst_n = 1'b1;
      instr = 4'b0111; alu = 16'h0777; rn = 4'd1; iv[0] = 1'b1;
      n_chk++; if (ir[0] !== 1'b1) $display("FAIL rst_in_ready: got %b exp 1", ir[0]); else n_pass++;
      @(posedge clk);
      #1;
      iv = 3'b000;
      n_chk++; if (ov[0] !== 1'b1 || wd[0] !== 16'h0777) $display("FAIL first_accept: got valid=%b data=%h exp 1/0777", ov[0], wd[0]); else n_pass++;
      drain();
   endtask

   task automatic test_store_load;
      int lat;
      issue(0, OP_STORE, 16'd5, 16'h00AB, 4'd2);
      wait_valid(0, lat);
      n_chk++; if (lat != 2) $display("FAIL store_latency: got %0d exp 2", lat); else n_pass++;
      n_chk++; if ({cwd[0], aerr[0], wd[0]} !== 18'h0) $display("FAIL store_result: got cwd=%b err=%b data=%h exp 0/0/0000", cwd[0], aerr[0], wd[0]); else n_pass++;
      drain();
      issue(0, OP_LOAD, 16'd5, 16'h0000, 4'd6);
      wait_valid(0, lat);
      n_chk++; if (lat != 2) $display("FAIL load_latency: got %0d exp 2", lat); else n_pass++;
      n_chk++; if (wd[0] !== 16'h00AB) $display("FAIL load_data: got %h exp 00ab", wd[0]); else n_pass++;
      n_chk++; if (rno[0] !== 4'd6 || cwd[0] !== 1'b1 || aerr[0] !== 1'b0) $display("FAIL load_ctrl: got reg=%0d cwd=%b err=%b exp 6/1/0", rno[0], cwd[0], aerr[0]); else n_pass++;
      drain();
   endtask

   task automatic test_pass;
      issue(0, 4'b0111, 16'h1234, 16'h5555, 4'd9);
      n_chk++; if (ov[0] !== 1'b1) $display("FAIL pass_valid: got %b exp 1", ov[0]); else n_pass++;
      n_chk++; if (wd[0] !== 16'h1234) $display("FAIL pass_data: got %h exp 1234", wd[0]); else n_pass++;
      n_chk++; if (rno[0] !== 4'd9 || cwd[0] !== 1'b1 || aerr[0] !== 1'b0) $display("FAIL pass_ctrl: got reg=%0d cwd=%b err=%b exp 9/1/0", rno[0], cwd[0], aerr[0]); else n_pass++;
      drain();
      n_chk++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) $display("FAIL pass_idle_gap: got valid=%b ready=%b exp 0/1", ov[0], ir[0]); else n_pass++;
   endtask

   task automatic test_addr_err;
      int lat;
      for (int i = 0; i < 16; i++) begin
         issue(0, OP_STORE, 16'(i), 16'hA000 + 16'(i), 4'd0);
         wait_valid(0, lat);
         drain();
      end
      issue(0, OP_LOAD, 16'h0015, 16'h0000, 4'd3);
      wait_valid(0, lat);
      n_chk++; if (lat != 2) $display("FAIL oor_load_latency: got %0d exp 2", lat); else n_pass++;
      n_chk++; if (aerr[0] !== 1'b1 || cwd[0] !== 1'b0 || wd[0] !== 16'h0) $display("FAIL oor_load: got err=%b cwd=%b data=%h exp 1/0/0000", aerr[0], cwd[0], wd[0]); else n_pass++;
      drain();
      issue(0, OP_STORE, 16'h0015, 16'hBEEF, 4'd0);
      wait_valid(0, lat);
      n_chk++; if (aerr[0] !== 1'b1 || cwd[0] !== 1'b0) $display("FAIL oor_store: got err=%b cwd=%b exp 1/0", aerr[0], cwd[0]); else n_pass++;
      drain();
      for (int i = 0; i < 16; i++) begin
         issue(0, OP_LOAD, 16'(i), 16'h0000, 4'(i));
         wait_valid(0, lat);
         n_chk++; if (wd[0] !== 16'hA000 + 16'(i)) $display("FAIL mem_unchanged[%0d]: got %h exp %h", i, wd[0], 16'hA000 + 16'(i)); else n_pass++;
         drain();
      end
   endtask

   task automatic test_backpressure;
      int lat;
      int extra;
      ordy = 1'b0;
      issue(0, 4'b0000, 16'h0042, 16'h0000, 4'd2);
      wait_valid(0, lat);
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin
            instr = OP_LOAD; alu = 16'd3; rn = 4'd7; iv[0] = 1'b1;
         end
         @(posedge clk);
         #1;
         iv = 3'b000;
         n_chk++; if (ov[0] !== 1'b1 || ir[0] !== 1'b0) $display("FAIL bp_hold_hs[%0d]: got valid=%b ready=%b exp 1/0", c, ov[0], ir[0]); else n_pass++;
         n_chk++; if (wd[0] !== 16'h0042 || rno[0] !== 4'd2 || cwd[0] !== 1'b1) $display("FAIL bp_hold_data[%0d]: got data=%h reg=%0d cwd=%b exp 0042/2/1", c, wd[0], rno[0], cwd[0]); else n_pass++;
      end
      ordy = 1'b1;
      @(posedge clk);
      #1;
      n_chk++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) $display("FAIL bp_release: got valid=%b ready=%b exp 0/1", ov[0], ir[0]); else n_pass++;
      extra = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (ov[0] === 1'b1) extra++;
      end
      n_chk++; if (extra != 0) $display("FAIL bp_no_queued: got %0d extra valid cycles exp 0", extra); else n_pass++;
   endtask

   task automatic test_reset_mid_access;
      int lat;
      // Result registers still hold the previous PASS result here.
      issue(0, OP_STORE, 16'd7, 16'h1111, 4'd5);
      #1;
      rst_n = 1'b0;
      #1;
      n_chk++; if (wd[0] !== 16'h0 || rno[0] !== 4'd0 || cwd[0] !== 1'b0) $display("FAIL async_rst_data: got data=%h reg=%0d cwd=%b exp 0000/0/0", wd[0], rno[0], cwd[0]); else n_pass++;
      n_chk++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) $display("FAIL async_rst_state: got valid=%b ready=%b exp 0/1", ov[0], ir[0]); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      issue(0, OP_LOAD, 16'd7, 16'h0000, 4'd1);
      wait_valid(0, lat);
      n_chk++; if (wd[0] !== 16'hA007) $display("FAIL aborted_store: got %h exp a007", wd[0]); else n_pass++;
      drain();
   endtask

   task automatic test_lat_sweep;
      int lat;
      for (int s = 1; s <= 2; s++) begin
         int exp_lat;
         exp_lat = (s == 1) ? 1 : 8;
         issue(s, OP_STORE, 16'd3, 16'h0030 + 16'(s), 4'd0);
         wait_valid(s, lat);
         n_chk++; if (lat != exp_lat) $display("FAIL sweep_store_lat[%0d]: got %0d exp %0d", s, lat, exp_lat); else n_pass++;
         drain();
         issue(s, OP_LOAD, 16'd3, 16'h0000, 4'd4);
         wait_valid(s, lat);
         n_chk++; if (lat != exp_lat) $display("FAIL sweep_load_lat[%0d]: got %0d exp %0d", s, lat, exp_lat); else n_pass++;
         n_chk++; if (wd[s] !== 16'h0030 + 16'(s) || rno[s] !== 4'd4) $display("FAIL sweep_load_data[%0d]: got %h/%0d exp %h/4", s, wd[s], rno[s], 16'h0030 + 16'(s)); else n_pass++;
         drain();
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_pass();
      test_addr_err();
      test_backpressure();
      test_reset_mid_access();
      test_lat_sweep();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
